// File: rtl/w5300_pkg.sv
// Shared types and constants for the W5300 register-access sequencer.
// Imported by the interface, the command FIFO and the sequencer top.
package w5300_pkg;

   localparam logic OP_RD = 1'b1;
   localparam logic OP_WR = 1'b0;

   localparam int DEFAULT_TIMEOUT = 64;
   localparam int BUS_CMD_W       = 11;
   localparam int CMD_W           = 35;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_BUSY,
      S_RESP
   } seq_state_t;

   // One queued host command as stored in the FIFO.
   typedef struct packed {
      logic        wr;
      logic [9:0]  addr;
      logic [15:0] wdata;
      logic [7:0]  len;
   } cmd_t;

endpackage

// File: rtl/w5300_reg_seq_if.sv
// Host request/response channel plus bus-engine channel of the sequencer.
// slave = sequencer side, master = host logic and bus engine side.
interface w5300_reg_seq_if;
   import w5300_pkg::*;

   logic                 req_valid;
   logic                 req_ready;
   logic                 req_wr;
   logic [9:0]           req_addr;
   logic [15:0]          req_wdata;
   logic [7:0]           req_len;

   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [15:0]          rsp_data;
   logic                 rsp_last;
   logic                 rsp_err;

   logic                 bus_valid;
   logic                 bus_ready;
   logic [BUS_CMD_W-1:0] bus_addr;
   logic [15:0]          bus_wdata;
   logic [15:0]          bus_rdata;

   modport slave (
      input  req_valid, req_wr, req_addr, req_wdata, req_len,
      output req_ready,
      output rsp_valid, rsp_data, rsp_last, rsp_err,
      input  rsp_ready,
      output bus_valid, bus_addr, bus_wdata,
      input  bus_ready, bus_rdata
   );

   modport master (
      output req_valid, req_wr, req_addr, req_wdata, req_len,
      input  req_ready,
      input  rsp_valid, rsp_data, rsp_last, rsp_err,
      output rsp_ready,
      input  bus_valid, bus_addr, bus_wdata,
      output bus_ready, bus_rdata
   );

endinterface

// File: rtl/w5300_cmd_fifo.sv
// Synchronous command FIFO with registered full/empty flags.
// A push is ignored while full, a pop is ignored while empty.
module w5300_cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 35
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic [AW:0]      count_nxt;
   logic             do_push;
   logic             do_pop;

   assign do_push   = push & ~full;
   assign do_pop    = pop & ~empty;
   assign count_nxt = count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
   assign rdata     = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   // Flags are computed from the next count so they are valid straight after the edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count_nxt;
         full  <= (count_nxt == (AW+1)'(DEPTH));
         empty <= (count_nxt == '0);
      end
   end

endmodule

// File: rtl/w5300_reg_seq.sv
// Serialises queued host register commands into single W5300 bus accesses,
// one response per access, with a per-access timeout.
module w5300_reg_seq
   import w5300_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
   input logic            clk,
   input logic            rst_n,
   w5300_reg_seq_if.slave sif
);
   localparam logic [9:0] TMO_LAST = 10'(TIMEOUT - 1);

   seq_state_t           state, state_nxt;
   cmd_t                 push_cmd, head;
   logic                 fifo_full, fifo_empty, pop;
   logic [7:0]           remaining, remaining_nxt;
   logic [9:0]           tmo_cnt, tmo_cnt_nxt;
   logic                 tmo_hit, to_err;
   logic                 seen_low, seen_low_nxt;
   logic                 bus_valid_r, bus_valid_nxt;
   logic [BUS_CMD_W-1:0] bus_addr_r, bus_addr_nxt;
   logic [15:0]          bus_wdata_r, bus_wdata_nxt;
   logic                 rsp_valid_r, rsp_valid_nxt;
   logic [15:0]          rsp_data_r, rsp_data_nxt;
   logic                 rsp_last_r, rsp_last_nxt;
   logic                 rsp_err_r, rsp_err_nxt;

   assign push_cmd = {sif.req_wr, sif.req_addr, sif.req_wdata, sif.req_wr ? 8'd0 : sif.req_len};

   w5300_cmd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(CMD_W)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (sif.req_valid),
      .pop   (pop),
      .wdata (push_cmd),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign sif.req_ready = ~fifo_full;
   assign sif.bus_valid = bus_valid_r;
   assign sif.bus_addr  = bus_addr_r;
   assign sif.bus_wdata = bus_wdata_r;
   assign sif.rsp_valid = rsp_valid_r;
   assign sif.rsp_data  = rsp_data_r;
   assign sif.rsp_last  = rsp_last_r;
   assign sif.rsp_err   = rsp_err_r;
   assign tmo_hit       = (tmo_cnt == TMO_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Every output is a flop loaded from its *_nxt value; timeout overrides the state logic.
   always_comb begin
      state_nxt     = state;
      pop           = 1'b0;
      to_err        = 1'b0;
      remaining_nxt = remaining;
      tmo_cnt_nxt   = tmo_cnt;
      seen_low_nxt  = seen_low;
      bus_valid_nxt = bus_valid_r;
      bus_addr_nxt  = bus_addr_r;
      bus_wdata_nxt = bus_wdata_r;
      rsp_valid_nxt = rsp_valid_r;
      rsp_data_nxt  = rsp_data_r;
      rsp_last_nxt  = rsp_last_r;
      rsp_err_nxt   = rsp_err_r;
      case (state)
         S_IDLE: begin
            if (!fifo_empty) begin
               pop           = 1'b1;
               remaining_nxt = head.wr ? 8'd0 : head.len;
               bus_addr_nxt  = {head.wr ? OP_WR : OP_RD, head.addr};
               bus_wdata_nxt = head.wdata;
               bus_valid_nxt = 1'b1;
               tmo_cnt_nxt   = '0;
               state_nxt     = S_ISSUE;
            end
         end
         S_ISSUE: begin
            tmo_cnt_nxt = tmo_hit ? tmo_cnt : tmo_cnt + 10'd1;
            if (tmo_hit) begin
               to_err = 1'b1;
            end else if (sif.bus_ready) begin
               bus_valid_nxt = 1'b0;
               seen_low_nxt  = 1'b0;
               state_nxt     = S_BUSY;
            end
         end
         S_BUSY: begin
            tmo_cnt_nxt = tmo_hit ? tmo_cnt : tmo_cnt + 10'd1;
            if (tmo_hit) begin
               to_err = 1'b1;
            end else if (seen_low && sif.bus_ready) begin
               rsp_valid_nxt = 1'b1;
               rsp_data_nxt  = (bus_addr_r[10] == OP_RD) ? sif.bus_rdata : 16'h0000;
               rsp_last_nxt  = (remaining == 8'd0);
               rsp_err_nxt   = 1'b0;
               state_nxt     = S_RESP;
            end else if (!sif.bus_ready) begin
               seen_low_nxt = 1'b1;
            end
         end
         S_RESP: begin
            if (sif.rsp_ready) begin
               rsp_valid_nxt = 1'b0;
               if (rsp_last_r) begin
                  state_nxt = S_IDLE;
               end else begin
                  remaining_nxt = remaining - 8'd1;
                  bus_valid_nxt = 1'b1;
                  tmo_cnt_nxt   = '0;
                  state_nxt     = S_ISSUE;
               end
            end
         end
         default: state_nxt = S_IDLE;
      endcase
      if (to_err) begin
         bus_valid_nxt = 1'b0;
         rsp_valid_nxt = 1'b1;
         rsp_data_nxt  = 16'h0000;
         rsp_last_nxt  = 1'b1;
         rsp_err_nxt   = 1'b1;
         state_nxt     = S_RESP;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         remaining   <= '0;
         tmo_cnt     <= '0;
         seen_low    <= 1'b0;
         bus_valid_r <= 1'b0;
         bus_addr_r  <= '0;
         bus_wdata_r <= '0;
         rsp_valid_r <= 1'b0;
         rsp_data_r  <= '0;
         rsp_last_r  <= 1'b0;
         rsp_err_r   <= 1'b0;
      end else begin
         remaining   <= remaining_nxt;
         tmo_cnt     <= tmo_cnt_nxt;
         seen_low    <= seen_low_nxt;
         bus_valid_r <= bus_valid_nxt;
         bus_addr_r  <= bus_addr_nxt;
         bus_wdata_r <= bus_wdata_nxt;
         rsp_valid_r <= rsp_valid_nxt;
         rsp_data_r  <= rsp_data_nxt;
         rsp_last_r  <= rsp_last_nxt;
         rsp_err_r   <= rsp_err_nxt;
      end
   end

endmodule

// File: tb/tb_w5300_reg_seq.sv
// Self-checking bench for w5300_reg_seq: queue scoreboard for bus commands and
// responses, a reactive bus-engine model, and directed latency/boundary checks.
module tb_w5300_reg_seq;
   import w5300_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic bus_stuck = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   stuck_valid_cnt = 0;

   logic [10:0] exp_bus_addr_q[$];
   logic [15:0] exp_bus_wdata_q[$];
   logic [15:0] bus_data_q[$];
   logic [17:0] exp_rsp_q[$];

   always #5 clk = ~clk;

   w5300_reg_seq_if sif();

   w5300_reg_seq #(.FIFO_DEPTH(4), .TIMEOUT(64)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .sif   (sif)
   );

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Queue expectations for one command, then hold req_valid until it is taken.
   task automatic applyStimulus(input logic wr, input logic [9:0] addr, input logic [15:0] wdata,
                                input logic [7:0] len, input logic [15:0] rd_base, input logic stuck);
      int beats;
      int waitc;
      logic [15:0] d;
      logic [17:0] e;
      beats = wr ? 1 : int'(len) + 1;
      if (stuck) begin
         exp_rsp_q.push_back({16'h0000, 1'b1, 1'b1});
      end else begin
         for (int i = 0; i < beats; i++) begin
            d = wr ? 16'h0000 : rd_base + 16'(i);
            e = {d, (i == beats - 1), 1'b0};
            exp_bus_addr_q.push_back({wr ? OP_WR : OP_RD, addr});
            exp_bus_wdata_q.push_back(wdata);
            if (!wr) bus_data_q.push_back(d);
            exp_rsp_q.push_back(e);
         end
      end
      sif.req_valid = 1'b1;
      sif.req_wr    = wr;
      sif.req_addr  = addr;
      sif.req_wdata = wdata;
      sif.req_len   = len;
      waitc = 0;
      while (1) begin
         @(negedge clk);
         if (sif.req_ready) break;
         waitc++;
         if (waitc >= 2000) begin
            checkOutput("req_accept", sif.req_ready, 1);
            break;
         end
      end
      @(posedge clk);
      #1;
      sif.req_valid = 1'b0;
   endtask

   task automatic drainRsp();
      int waitc = 0;
      while (exp_rsp_q.size() != 0 && waitc < 1000) begin
         @(negedge clk);
         waitc++;
      end
      checkOutput("rsp_drain", exp_rsp_q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   // Bus engine: accepts on valid&ready, drops ready for 1..4 cycles, then completes.
   initial begin : bus_model
      int phase;
      int busy_left;
      logic [10:0] cur_cmd;
      logic just_done;
      logic [15:0] ew;
      phase = 0;
      busy_left = 0;
      cur_cmd = '0;
      just_done = 1'b0;
      sif.bus_ready = 1'b1;
      sif.bus_rdata = 16'h0000;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            phase = 0;
            just_done = 1'b0;
            sif.bus_ready = 1'b1;
         end else begin
            if (just_done) begin
               checkOutput("rsp_latency", sif.rsp_valid, 1);
               just_done = 1'b0;
            end
            case (phase)
               0: begin
                  sif.bus_ready = !bus_stuck;
                  if (sif.bus_ready && sif.bus_valid) begin
                     checkOutput("bus_q_nonempty", exp_bus_addr_q.size() != 0, 1);
                     if (exp_bus_addr_q.size() != 0) begin
                        checkOutput("bus_addr", sif.bus_addr, exp_bus_addr_q.pop_front());
                        ew = exp_bus_wdata_q.pop_front();
                        if (sif.bus_addr[10] == OP_WR) checkOutput("bus_wdata", sif.bus_wdata, ew);
                     end
                     cur_cmd = sif.bus_addr;
                     phase = 1;
                  end
               end
               1: begin
                  sif.bus_ready = 1'b0;
                  sif.bus_rdata = 16'($urandom);
                  busy_left = $urandom_range(0, 3);
                  phase = 2;
               end
               default: begin
                  if (busy_left > 0) begin
                     busy_left--;
                  end else begin
                     sif.bus_ready = 1'b1;
                     if (cur_cmd[10] == OP_RD)
                        sif.bus_rdata = (bus_data_q.size() != 0) ? bus_data_q.pop_front() : 16'hDEAD;
                     just_done = 1'b1;
                     phase = 0;
                  end
               end
            endcase
         end
      end
   end

   initial begin : rsp_monitor
      logic [17:0] e;
      forever begin
         @(negedge clk);
         if (rst_n && sif.rsp_valid && sif.rsp_ready) begin
            checkOutput("rsp_q_nonempty", exp_rsp_q.size() != 0, 1);
            if (exp_rsp_q.size() != 0) begin
               e = exp_rsp_q.pop_front();
               checkOutput("rsp_data", sif.rsp_data, e[17:2]);
               checkOutput("rsp_last", sif.rsp_last, e[1]);
               checkOutput("rsp_err", sif.rsp_err, e[0]);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (bus_stuck && sif.bus_valid) stuck_valid_cnt++;
   end

   initial begin : watchdog
      #2000000;
      $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : main
      int waitc;
      sif.req_valid = 1'b0;
      sif.req_wr    = 1'b0;
      sif.req_addr  = '0;
      sif.req_wdata = '0;
      sif.req_len   = '0;
      sif.rsp_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_req_ready", sif.req_ready, 1);
      checkOutput("rst_rsp_valid", sif.rsp_valid, 0);
      checkOutput("rst_rsp_data", sif.rsp_data, 0);
      checkOutput("rst_rsp_last", sif.rsp_last, 0);
      checkOutput("rst_rsp_err", sif.rsp_err, 0);
      checkOutput("rst_bus_valid", sif.bus_valid, 0);
      checkOutput("rst_bus_addr", sif.bus_addr, 0);
      checkOutput("rst_bus_wdata", sif.bus_wdata, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Single write: bus_valid must appear two cycles after the push cycle.
      applyStimulus(1'b1, 10'h200, 16'hA5A5, 8'd0, 16'h0, 1'b0);
      @(negedge clk);
      checkOutput("lat_t1_bus_valid", sif.bus_valid, 0);
      @(negedge clk);
      checkOutput("lat_t2_bus_valid", sif.bus_valid, 1);
      checkOutput("lat_t2_bus_addr", sif.bus_addr, 11'h200);
      checkOutput("lat_t2_bus_wdata", sif.bus_wdata, 16'hA5A5);
      drainRsp();

      applyStimulus(1'b0, 10'h201, 16'h0, 8'd0, 16'h1234, 1'b0);
      @(negedge clk);
      @(negedge clk);
      checkOutput("rd_bus_addr", sif.bus_addr, 11'h601);
      drainRsp();

      applyStimulus(1'b0, 10'h230, 16'h0, 8'd3, 16'h0001, 1'b0);
      drainRsp();

      // Host withholds rsp_ready during a burst.
      sif.rsp_ready = 1'b0;
      applyStimulus(1'b0, 10'h240, 16'h0, 8'd3, 16'h0050, 1'b0);
      waitc = 0;
      while (!sif.rsp_valid && waitc < 200) begin
         @(negedge clk);
         waitc++;
      end
      checkOutput("hold_rsp_seen", sif.rsp_valid, 1);
      for (int i = 0; i < 20; i++) begin
         checkOutput("hold_bus_valid", sif.bus_valid, 0);
         checkOutput("hold_rsp_valid", sif.rsp_valid, 1);
         checkOutput("hold_rsp_data", sif.rsp_data, 16'h0050);
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      sif.rsp_ready = 1'b1;
      drainRsp();

      // FIFO fill while the bus makes no progress.
      bus_stuck = 1'b1;
      for (int k = 0; k < 5; k++) begin
         applyStimulus(1'b1, 10'h300 + 10'(k), 16'h1000 + 16'(k), 8'd0, 16'h0, 1'b0);
         if (k == 3) checkOutput("fifo_ready_after4", sif.req_ready, 1);
         if (k == 4) checkOutput("fifo_full_after5", sif.req_ready, 0);
      end
      bus_stuck = 1'b0;
      applyStimulus(1'b1, 10'h305, 16'h1005, 8'd0, 16'h0, 1'b0);
      drainRsp();

      // Timeout with a stuck bus engine, then a normal queued read.
      stuck_valid_cnt = 0;
      bus_stuck = 1'b1;
      applyStimulus(1'b1, 10'h3A0, 16'hBEEF, 8'd0, 16'h0, 1'b1);
      applyStimulus(1'b0, 10'h3A1, 16'h0, 8'd0, 16'h7777, 1'b0);
      waitc = 0;
      while (!sif.rsp_valid && waitc < 300) begin
         @(negedge clk);
         waitc++;
      end
      checkOutput("tmo_rsp_seen", sif.rsp_valid, 1);
      checkOutput("tmo_valid_cycles", stuck_valid_cnt, 64);
      @(posedge clk);
      #1;
      bus_stuck = 1'b0;
      drainRsp();

      // Reset in the middle of an access with another command queued.
      bus_stuck = 1'b1;
      for (int k = 0; k < 2; k++) begin
         sif.req_valid = 1'b1;
         sif.req_wr    = 1'b1;
         sif.req_addr  = 10'h3F0 + 10'(k);
         sif.req_wdata = 16'h5555;
         sif.req_len   = 8'd0;
         @(posedge clk);
         #1;
      end
      sif.req_valid = 1'b0;
      waitc = 0;
      while (!sif.bus_valid && waitc < 20) begin
         @(negedge clk);
         waitc++;
      end
      checkOutput("mid_bus_valid", sif.bus_valid, 1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async_bus_valid", sif.bus_valid, 0);
      checkOutput("async_bus_addr", sif.bus_addr, 0);
      checkOutput("async_req_ready", sif.req_ready, 1);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checkOutput("post_rst_idle", sif.bus_valid, 0);
      end
      bus_stuck = 1'b0;

      checkOutput("bus_q_drained", exp_bus_addr_q.size(), 0);
      checkOutput("bus_data_drained", bus_data_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/w5300_reg_seq.md
# w5300_reg_seq

Register-access sequencer sitting directly upstream of the W5300 parallel-bus engine. It accepts read/write/burst-read commands from host logic through a small command FIFO. It serialises them into single bus transactions and returns one response per bus access. It also enforces a per-access timeout so a hung bus engine cannot stall the host.

## Interface
Parameters:
- FIFO_DEPTH, 4: command FIFO entries; power of two, 2..16.
- TIMEOUT, 64: max cycles spent waiting in S_ISSUE or S_BUSY for one access; 8..1023.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- req_valid  in  1  host command valid.
- req_ready  out  1  command FIFO not full.
- req_wr  in  1  1 = write, 0 = read.
- req_addr  in  10  W5300 register address.
- req_wdata  in  16  write data; ignored for reads.
- req_len  in  8  read burst length minus one, repeated at the same address; forced to 0 for writes.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  host accepts response.
- rsp_data  out  16  read data; 0 for writes and errors.
- rsp_last  out  1  final response of the command.
- rsp_err  out  1  access timed out.
- bus_valid  out  1  command presented to bus engine.
- bus_ready  in  1  bus engine idle; held low for the whole duration of an access.
- bus_addr  out  11  {op, addr}; op bit10: 1 = read, 0 = write.
- bus_wdata  out  16  write data to bus engine.
- bus_rdata  in  16  read data, valid on the cycle bus_ready returns high.

## Operation
- Command push: when req_valid & req_ready. req_ready = !full, registered, with no same-cycle pop bypass.
- States:
  - S_IDLE: if the FIFO is not empty, pop the head, load remaining count = len (0 for writes), and go to S_ISSUE.
  - S_ISSUE: bus_valid = 1 with bus_addr and bus_wdata stable. Handshake occurs on bus_valid & bus_ready; then go to S_BUSY.
  - S_BUSY: wait for bus_ready to go low and then high again. On that high edge (the completion cycle), capture bus_rdata for reads or 0 for writes, then go to S_RESP.
  - S_RESP: rsp_valid = 1. rsp_last = (remaining == 0) | err.
    - On rsp_ready with last set: go to S_IDLE.
    - On rsp_ready without last: decrement remaining and go to S_ISSUE.
- Timeout counter:
  - Clears on entry to S_ISSUE.
  - Counts in S_ISSUE and S_BUSY.
  - Reaching TIMEOUT-1 goes to S_RESP with rsp_err = 1, rsp_data = 0, rsp_last = 1. The remaining burst beats are dropped and bus_valid is deasserted.
- Backpressure: no new bus access is issued while a response is pending, so each read is issued only after the previous response is accepted.
- Ordering: strict FIFO order, with one command in flight.
- Reset mid-access: all state clears immediately. The FIFO empties and any in-flight response is lost. bus_valid drops asynchronously.

## Timing
- Reset values:
  - req_ready = 1.
  - rsp_valid = 0, rsp_data = 0, rsp_last = 0, rsp_err = 0.
  - bus_valid = 0, bus_addr = 0, bus_wdata = 0.
- All outputs are registered.
- FIFO-to-bus latency: a command pushed at cycle t into an empty FIFO, with the sequencer idle, gives bus_valid = 1 at t+2.
- Response latency: rsp_valid rises one cycle after the bus_ready rising cycle.
- Burst spacing: the next bus_valid comes one cycle after the rsp_valid & rsp_ready handshake.
- Full FIFO: simultaneous push and pop is refused (req_ready was 0), so the host must retry.
- Width rules:
  - Remaining count is 8 bits; it never wraps because it stops at 0.
  - Timeout counter is 10 bits, saturating.

## Structure
- Package w5300_pkg holds:
  - OP_RD = 1'b1, OP_WR = 1'b0.
  - Sequencer state enum {S_IDLE, S_ISSUE, S_BUSY, S_RESP}.
  - Default TIMEOUT.
  - Bus command width 11.
- Sub-module w5300_cmd_fifo: synchronous FIFO, width 35 ({wr, addr, wdata, len} = 1+10+16+8), with registered full and empty flags.

## Test plan
- Single write addr 0x200, data 0xA5A5 → bus_addr = 0x200, bus_wdata = 0xA5A5 at t+2; one response: rsp_data = 0, rsp_last = 1, rsp_err = 0.
- Single read addr 0x201, bus model returns 0x1234 → bus_addr = 0x601; rsp_data = 0x1234, rsp_last = 1.
- Burst read len = 3 at 0x230, model returns 1, 2, 3, 4 → four bus accesses; responses 1, 2, 3, 4 with rsp_last only on the 4th.
- Push 5 commands without bus progress → req_ready = 0 after the 4th push is stored plus one in flight; 5th accepted after the first pop; order preserved.
- Hold rsp_ready = 0 for 20 cycles during a burst → no bus_valid while rsp_valid is held; rsp_data stable.
- Bus model never completes (bus_ready stuck low) → after 64 cycles rsp_err = 1, rsp_last = 1, rsp_data = 0; the next queued command then issues normally.
